// File: rtl/cnt_pair_sched.sv
// Two-requester round-robin scheduler driving a counter pair (v, imp) whose
// values are held complementary; ops are LOAD (set v) and STEP (increment v N times).
module cnt_pair_sched #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic         op0,
  input  logic         op1,
  input  logic [W-1:0] arg0,
  input  logic [W-1:0] arg1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic         busy,
  output logic [W-1:0] v,
  output logic [W-1:0] out,
  output logic         inv_ok
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STEP, S_DONE} state_t;

  state_t       state, state_nx;
  logic [W-1:0] imp;
  logic [W-1:0] rem;
  logic [W-1:0] arg_q;
  logic         owner;
  logic         rr;
  logic         first;
  logic         any_req;
  logic         win;
  logic         win_op;
  logic [W-1:0] win_arg;

  always_comb begin
    any_req = req0 | req1;
    win     = (req0 & req1) ? rr : req1;
    win_op  = win ? op1 : op0;
    win_arg = win ? arg1 : arg0;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (any_req) state_nx = win_op ? S_STEP : S_LOAD;
      S_LOAD: state_nx = S_DONE;
      // The last increment happens on the cycle rem goes 1 -> 0; N = 0 leaves after one idle STEP cycle.
      S_STEP: if (rem <= W'(1)) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v     <= '0;
      imp   <= '1;
      rem   <= '0;
      arg_q <= '0;
      owner <= 1'b0;
      rr    <= 1'b0;
      first <= 1'b0;
    end else begin
      first <= 1'b0;
      case (state)
        S_IDLE: if (any_req) begin
          owner <= win;
          arg_q <= win_arg;
          rem   <= win_arg;
          first <= 1'b1;
        end
        S_LOAD: begin
          v   <= arg_q;
          imp <= ~arg_q;
        end
        S_STEP: if (rem != '0) begin
          v   <= v + 1'b1;
          imp <= imp - 1'b1;
          rem <= rem - 1'b1;
        end
        S_DONE: rr <= ~owner;
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt0   = first & ~owner;
    gnt1   = first & owner;
    done0  = (state == S_DONE) & ~owner;
    done1  = (state == S_DONE) & owner;
    busy   = (state != S_IDLE);
    out    = v & ~imp;
    inv_ok = (v == ~imp);
  end

endmodule
